// File: rtl/beam_reg_bank_pkg.sv
// +----------------------------------------------------------------------------+
// | beam_scanner_pkg                                                           |
// | Register map, CTRL bit positions, reset defaults and FSM states.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package beam_scanner_pkg;

  localparam int REG_CTRL        = 0;
  localparam int REG_ANGLE_START = 1;
  localparam int REG_ANGLE_STOP  = 2;
  localparam int REG_ANGLE_STEP  = 3;
  localparam int REG_PRF_DIV     = 4;
  localparam int REG_GATE_DEPTH  = 5;
  localparam int REG_GAIN        = 6;
  localparam int REG_STATUS      = 7;

  localparam int CTRL_SCAN_ENABLE = 0;
  localparam int CTRL_SCAN_START  = 1;
  localparam int CTRL_ERR_CLR     = 15;

  localparam int ADDR_READ_BIT = 7;

  localparam logic [15:0] RST_ANGLE_STEP = 16'h0001;
  localparam logic [15:0] RST_PRF_DIV    = 16'h0100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RD_HI = 2'd2,
    RD_LO = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/beam_reg_bank_if.sv
// +----------------------------------------------------------------------------+
// | beam_reg_bank_if                                                           |
// | SPI command word in, readback byte stream out.                             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface beam_reg_bank_if;
  logic [7:0]  reg_addr;
  logic [15:0] reg_value;
  logic        transfered;
  logic [15:0] status_in;
  logic        send_data_mode;
  logic [7:0]  data_out;

  modport master (
    output reg_addr, reg_value, transfered, status_in,
    input  send_data_mode, data_out
  );

  modport slave (
    input  reg_addr, reg_value, transfered, status_in,
    output send_data_mode, data_out
  );
endinterface

`default_nettype wire

// File: rtl/beam_reg_bank_pulse_sync.sv
// +----------------------------------------------------------------------------+
// | pulse_sync                                                                 |
// | Level synchroniser into clk with a one-cycle rising-edge pulse output.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pulse_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic level_in,
  output logic pulse_out
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], level_in};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign pulse_out = r_sync[STAGES-1] & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/beam_reg_bank.sv
// +----------------------------------------------------------------------------+
// | beam_reg_bank                                                              |
// | SPI command decode into beam-scanner control registers, 2-byte readback.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module beam_reg_bank
  import beam_scanner_pkg::*;
#(
  parameter int NREGS       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  beam_reg_bank_if.slave    spi,
  output logic              scan_enable,
  output logic              scan_start,
  output logic [15:0]       angle_start,
  output logic [15:0]       angle_stop,
  output logic [15:0]       angle_step,
  output logic [15:0]       prf_div,
  output logic [15:0]       gate_depth,
  output logic [15:0]       gain,
  output logic              wr_strobe,
  output logic              err_addr
);

  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_t      r_state;
  state_t      w_next;
  logic        w_xfer;
  logic [6:0]  r_idx;
  logic [15:0] r_value;
  logic [15:0] r_rdata;
  logic [15:0] r_regs [NREGS];
  logic        r_wr_strobe;
  logic        r_scan_start;
  logic        r_err;
  logic        w_addr_ok;
  logic        w_wr_ok;
  logic [15:0] w_rd_word;

  pulse_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .level_in  (spi.transfered),
    .pulse_out (w_xfer)
  );

  assign w_addr_ok = ({1'b0, spi.reg_addr[6:0]} < 8'(NREGS));
  assign w_wr_ok   = ({1'b0, r_idx} < 8'(NREGS));

  always_comb begin
    w_rd_word = 16'h0000;
    if (w_addr_ok) begin
      if (spi.reg_addr[6:0] == 7'(REG_STATUS))
        w_rd_word = spi.status_in;
      else
        w_rd_word = r_regs[spi.reg_addr[IW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next             = r_state;
    spi.send_data_mode = 1'b0;
    spi.data_out       = 8'h00;
    case (r_state)
      IDLE:  if (w_xfer) w_next = spi.reg_addr[ADDR_READ_BIT] ? RD_HI : WRITE;
      WRITE: w_next = IDLE;
      RD_HI: begin
        spi.send_data_mode = 1'b1;
        spi.data_out       = r_rdata[15:8];
        if (w_xfer) w_next = RD_LO;
      end
      RD_LO: begin
        spi.send_data_mode = 1'b1;
        spi.data_out       = r_rdata[7:0];
        if (w_xfer) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx        <= '0;
      r_value      <= '0;
      r_rdata      <= '0;
      r_wr_strobe  <= 1'b0;
      r_scan_start <= 1'b0;
      r_err        <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= 16'h0000;
      r_regs[REG_ANGLE_STEP] <= RST_ANGLE_STEP;
      r_regs[REG_PRF_DIV]    <= RST_PRF_DIV;
    end else begin
      r_wr_strobe  <= 1'b0;
      r_scan_start <= 1'b0;

      // Command fields are only trusted in the cycle the strobe arrives.
      if (r_state == IDLE && w_xfer) begin
        r_idx   <= spi.reg_addr[6:0];
        r_value <= spi.reg_value;
        if (spi.reg_addr[ADDR_READ_BIT]) begin
          r_rdata <= w_rd_word;
          if (!w_addr_ok) r_err <= 1'b1;
        end
      end

      if (r_state == WRITE) begin
        if (w_wr_ok) begin
          r_wr_strobe <= 1'b1;
          if (r_idx == 7'(REG_CTRL)) begin
            r_regs[REG_CTRL] <= {15'b0, r_value[CTRL_SCAN_ENABLE]};
            r_scan_start     <= r_value[CTRL_SCAN_START];
            if (r_value[CTRL_ERR_CLR]) r_err <= 1'b0;
          end else if (r_idx != 7'(REG_STATUS)) begin
            r_regs[r_idx[IW-1:0]] <= r_value;
          end
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign scan_enable = r_regs[REG_CTRL][CTRL_SCAN_ENABLE];
  assign scan_start  = r_scan_start;
  assign angle_start = r_regs[REG_ANGLE_START];
  assign angle_stop  = r_regs[REG_ANGLE_STOP];
  assign angle_step  = r_regs[REG_ANGLE_STEP];
  assign prf_div     = r_regs[REG_PRF_DIV];
  assign gate_depth  = r_regs[REG_GATE_DEPTH];
  assign gain        = r_regs[REG_GAIN];
  assign wr_strobe   = r_wr_strobe;
  assign err_addr    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_beam_reg_bank.sv
// +----------------------------------------------------------------------------+
// | tb_beam_reg_bank                                                           |
// | Directed bench for beam_reg_bank with a readback byte scoreboard.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_beam_reg_bank;

  logic        clk;
  logic        reset;
  logic        scan_enable;
  logic        scan_start;
  logic [15:0] angle_start;
  logic [15:0] angle_stop;
  logic [15:0] angle_step;
  logic [15:0] prf_div;
  logic [15:0] gate_depth;
  logic [15:0] gain;
  logic        wr_strobe;
  logic        err_addr;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulse;
  logic [7:0] exp_q[$];

  beam_reg_bank_if bus ();

  beam_reg_bank #(.NREGS(8), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .spi         (bus),
    .scan_enable (scan_enable),
    .scan_start  (scan_start),
    .angle_start (angle_start),
    .angle_stop  (angle_stop),
    .angle_step  (angle_step),
    .prf_div     (prf_div),
    .gate_depth  (gate_depth),
    .gain        (gain),
    .wr_strobe   (wr_strobe),
    .err_addr    (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_byte(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: observed empty scoreboard expected a byte", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, {8'h00, bus.data_out}, {8'h00, e});
    end
  endtask

  // Full command: transfered held high 6 clk, then low 4 clk; returns on a negedge.
  task automatic xfer(input logic [7:0] a, input logic [15:0] v);
    @(negedge clk);
    bus.reg_addr   = a;
    bus.reg_value  = v;
    bus.transfered = 1'b1;
    repeat (6) @(negedge clk);
    bus.transfered = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_defaults(input string tag);
    check({tag, "_prf"},   prf_div,    16'h0100);
    check({tag, "_step"},  angle_step, 16'h0001);
    check({tag, "_start"}, angle_start, 16'h0000);
    check({tag, "_gain"},  gain,       16'h0000);
    check({tag, "_en"},    {15'b0, scan_enable}, 16'h0000);
    check({tag, "_err"},   {15'b0, err_addr},    16'h0000);
    check({tag, "_sdm"},   {15'b0, bus.send_data_mode}, 16'h0000);
    check({tag, "_dout"},  {8'h00, bus.data_out}, 16'h0000);
  endtask

  initial begin
    reset          = 1'b1;
    bus.reg_addr   = 8'h00;
    bus.reg_value  = 16'h0000;
    bus.transfered = 1'b0;
    bus.status_in  = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // 1. reset values
    check_defaults("rst");
    check("rst_stop", angle_stop, 16'h0000);
    check("rst_depth", gate_depth, 16'h0000);
    check("rst_wrs", {15'b0, wr_strobe}, 16'h0000);

    // 2. write latency: update lands on the 4th rising edge after transfered rises
    @(negedge clk);
    bus.reg_addr   = 8'h03;
    bus.reg_value  = 16'h0040;
    bus.transfered = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("lat_early_step", angle_step, 16'h0001);
    check("lat_early_wrs", {15'b0, wr_strobe}, 16'h0000);
    @(posedge clk);
    #1;
    check("lat_step", angle_step, 16'h0040);
    check("lat_wrs", {15'b0, wr_strobe}, 16'h0001);
    @(posedge clk);
    #1;
    check("lat_wrs_end", {15'b0, wr_strobe}, 16'h0000);
    repeat (4) @(negedge clk);
    bus.transfered = 1'b0;
    repeat (4) @(negedge clk);

    // 3. CTRL write: scan_enable held, scan_start exactly one clk
    @(negedge clk);
    bus.reg_addr   = 8'h00;
    bus.reg_value  = 16'h0003;
    bus.transfered = 1'b1;
    n_pulse = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (scan_start) n_pulse++;
    end
    check("start_pulse_cnt", 16'(n_pulse), 16'd1);
    bus.transfered = 1'b0;
    repeat (4) @(negedge clk);
    check("scan_en", {15'b0, scan_enable}, 16'h0001);

    // 4. write reg 5 then read it back
    xfer(8'h05, 16'h1234);
    check("depth", gate_depth, 16'h1234);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    xfer(8'h85, 16'h0000);
    check("rd5_sdm", {15'b0, bus.send_data_mode}, 16'h0001);
    check_byte("rd5_hi");
    xfer(8'h06, 16'hFFFF);
    check("rd5_sdm_lo", {15'b0, bus.send_data_mode}, 16'h0001);
    check_byte("rd5_lo");
    check("rd_no_write", gain, 16'h0000);
    xfer(8'h00, 16'h0000);
    check("rd5_sdm_end", {15'b0, bus.send_data_mode}, 16'h0000);
    check("rd5_dout_end", {8'h00, bus.data_out}, 16'h0000);

    // 5. invalid write sets err and is dropped; CTRL bit15 clears it
    @(negedge clk);
    bus.reg_addr   = 8'h0A;
    bus.reg_value  = 16'h5555;
    bus.transfered = 1'b1;
    n_pulse = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (wr_strobe) n_pulse++;
    end
    check("bad_wr_strobes", 16'(n_pulse), 16'd0);
    bus.transfered = 1'b0;
    repeat (4) @(negedge clk);
    check("bad_err", {15'b0, err_addr}, 16'h0001);
    check("bad_step", angle_step, 16'h0040);
    check("bad_depth", gate_depth, 16'h1234);
    check("bad_prf", prf_div, 16'h0100);
    check("bad_en", {15'b0, scan_enable}, 16'h0001);
    xfer(8'h00, 16'h8000);
    check("clr_err", {15'b0, err_addr}, 16'h0000);
    check("clr_en", {15'b0, scan_enable}, 16'h0000);

    // invalid read returns zero and flags err
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    bus.status_in = 16'hFFFF;
    xfer(8'h8A, 16'h0000);
    check("badrd_err", {15'b0, err_addr}, 16'h0001);
    check_byte("badrd_hi");
    xfer(8'h00, 16'h0000);
    check_byte("badrd_lo");
    xfer(8'h00, 16'h0000);
    xfer(8'h00, 16'h8000);
    check("badrd_clr", {15'b0, err_addr}, 16'h0000);

    // 6. status readback frozen at request time
    bus.status_in = 16'hBEEF;
    exp_q.push_back(8'hBE);
    exp_q.push_back(8'hEF);
    xfer(8'h87, 16'h0000);
    bus.status_in = 16'h0000;
    check_byte("st_hi");
    xfer(8'h00, 16'h0000);
    check_byte("st_lo");
    xfer(8'h00, 16'h0000);
    check("st_sdm_end", {15'b0, bus.send_data_mode}, 16'h0000);

    // reset during readback drops send_data_mode without a clock edge
    bus.status_in = 16'hBEEF;
    exp_q.push_back(8'hBE);
    exp_q.push_back(8'hEF);
    xfer(8'h87, 16'h0000);
    check_byte("rst_rd_hi");
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_rd_sdm", {15'b0, bus.send_data_mode}, 16'h0000);
    check("rst_rd_dout", {8'h00, bus.data_out}, 16'h0000);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_defaults("rst2");
    check("rst2_depth", gate_depth, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
